// File: rtl/mt_mnt_seq_pkg.sv
// Shared maintenance-sequencer definitions: MTMR opcodes and sequencer states.
// Imported by the sequencer and by the MT register decode.
package mt_mnt_pkg;

  localparam logic [3:0] MOP_NOP  = 4'h0;
  localparam logic [3:0] MOP_WRP1 = 4'h1;
  localparam logic [3:0] MOP_WRP2 = 4'h2;
  localparam logic [3:0] MOP_WRP3 = 4'h3;

  localparam int GAP_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    XFER,
    GAP,
    DONE
  } mntstate_t;

  function automatic logic is_wrp(input logic [3:0] op);
    return (op == MOP_WRP1) || (op == MOP_WRP2) || (op == MOP_WRP3);
  endfunction

endpackage

// File: rtl/mt_mnt_seq_if.sv
// Frame source stream from the MT data buffer into the maintenance sequencer.
// frm_ready is a one-cycle accept strobe; the source advances after seeing it.
interface mt_mnt_seq_if #(
  parameter int MDF_W = 9
);
  logic [MDF_W-1:0] frm_data;
  logic             frm_valid;
  logic             frm_last;
  logic             frm_ready;

  modport master (output frm_data, output frm_valid, output frm_last, input frm_ready);
  modport slave  (input frm_data, input frm_valid, input frm_last, output frm_ready);
endinterface

// File: rtl/mt_mnt_seq_edge_det.sv
// Rising-edge detector: 2-flop history, rise is a one-cycle pulse one clock
// after the sampled level goes high; no backpressure.
module mt_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (!rst) hist <= 2'b00;
    else      hist <= {hist[0], sig};
  end

  assign rise = hist[0] & ~hist[1];

endmodule

// File: rtl/mt_mnt_seq.sv
// Maintenance wraparound sequencer: one frame per BPI tick onto MDF, then gap and done.
// Optional MTMNT_PARITY_EN replaces mdf MSB with odd parity of the low frame bits.
module mt_mnt_seq
  import mt_mnt_pkg::*;
#(
  parameter int MDF_W     = 9,
  parameter int FC_W      = 16,
  parameter int GAP_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mm,
  input  logic [3:0]       mop,
  input  logic             go,
  input  logic             bpiclk,
  input  logic             fc_load,
  input  logic [FC_W-1:0]  fc_data,
  mt_mnt_seq_if.slave      frm,
  output logic [MDF_W-1:0] mdf,
  output logic             mc,
  output logic             busy,
  output logic             done,
  output logic             fc_zero,
  output logic             err_unr
);

  mntstate_t        state, state_n;
  logic [MDF_W-1:0] mdf_n, frame;
  logic             mc_n, err_n, rdy, rdy_n, fc_zero_n, tick;
  logic [FC_W-1:0]  fc, fc_n;
  logic [GAP_W-1:0] gap, gap_n;

  mt_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (bpiclk),
    .rise (tick)
  );

`ifdef MTMNT_PARITY_EN
  assign frame = {^frm.frm_data[MDF_W-2:0], frm.frm_data[MDF_W-2:0]};
`else
  assign frame = frm.frm_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      mdf     <= '0;
      mc      <= 1'b0;
      rdy     <= 1'b0;
      err_unr <= 1'b0;
      fc      <= '0;
      fc_zero <= 1'b1;
      gap     <= '0;
    end else begin
      state   <= state_n;
      mdf     <= mdf_n;
      mc      <= mc_n;
      rdy     <= rdy_n;
      err_unr <= err_n;
      fc      <= fc_n;
      fc_zero <= fc_zero_n;
      gap     <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    mdf_n   = mdf;
    mc_n    = mc;
    rdy_n   = 1'b0;
    err_n   = err_unr;
    fc_n    = fc;
    gap_n   = gap;
    case (state)
      IDLE: begin
        if (fc_load) fc_n = fc_data;
        if (go && mm && is_wrp(mop)) begin
          state_n = ARM;
          err_n   = 1'b0;
        end
      end
      ARM: begin
        if (!mm) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else if (tick) begin
          state_n = XFER;
        end
      end
      XFER: begin
        // Abort takes priority over a coincident tick: no frame is taken.
        if (!mm) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else if (tick) begin
          if (frm.frm_valid) begin
            mdf_n = frame;
            rdy_n = 1'b1;
            mc_n  = ~mc;
            fc_n  = (fc == '0) ? '0 : fc - FC_W'(1);
            if (frm.frm_last || fc_n == '0) begin
              state_n = GAP;
              gap_n   = GAP_W'(GAP_TICKS);
            end
          end else begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end
      end
      GAP: begin
        mdf_n = '0;
        if (!mm) begin
          err_n   = 1'b1;
          state_n = DONE;
        end else if (tick) begin
          if (gap <= GAP_W'(1)) begin
            gap_n   = '0;
            state_n = DONE;
          end else begin
            gap_n = gap - GAP_W'(1);
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    fc_zero_n = (fc_n == '0);
  end

  assign frm.frm_ready = rdy;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_mt_mnt_seq.sv
// Directed bench for mt_mnt_seq; expected values are hand-derived per step.
module tb_mt_mnt_seq;
  import mt_mnt_pkg::*;

  localparam int MDF_W     = 9;
  localparam int FC_W      = 16;
  localparam int GAP_TICKS = 4;

  logic             clk = 1'b0;
  logic             rst, mm, go, bpiclk, fc_load;
  logic [3:0]       mop;
  logic [FC_W-1:0]  fc_data;
  logic [MDF_W-1:0] mdf;
  logic             mc, busy, done, fc_zero, err_unr;
  logic             exp_mc;
  int               checks = 0;
  int               errors = 0;

  mt_mnt_seq_if #(.MDF_W(MDF_W)) frm_if ();

  mt_mnt_seq #(.MDF_W(MDF_W), .FC_W(FC_W), .GAP_TICKS(GAP_TICKS)) dut (
    .clk     (clk),
    .rst     (rst),
    .mm      (mm),
    .mop     (mop),
    .go      (go),
    .bpiclk  (bpiclk),
    .fc_load (fc_load),
    .fc_data (fc_data),
    .frm     (frm_if),
    .mdf     (mdf),
    .mc      (mc),
    .busy    (busy),
    .done    (done),
    .fc_zero (fc_zero),
    .err_unr (err_unr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the clock edge on which the sequencer sees the tick.
  task automatic tick_bpi();
    step();
    bpiclk = 1'b1;
    step();
    step();
    bpiclk = 1'b0;
  endtask

  function automatic logic [MDF_W-1:0] exp_of(input logic [MDF_W-1:0] d);
`ifdef MTMNT_PARITY_EN
    return {^d[7:0], d[7:0]};
`else
    return d;
`endif
  endfunction

  task automatic start(input logic [FC_W-1:0] n, input logic [3:0] op);
    fc_load = 1'b1;
    fc_data = n;
    step();
    fc_load = 1'b0;
    mm  = 1'b1;
    mop = op;
    go  = 1'b1;
    step();
    go = 1'b0;
    check("busy_after_go", busy, 1);
    check("err_clr_on_go", err_unr, 0);
    tick_bpi();
    check("arm_no_ready", frm_if.frm_ready, 0);
  endtask

  task automatic send(input logic [MDF_W-1:0] d, input logic last, input logic [MDF_W-1:0] exp_mdf);
    frm_if.frm_data  = d;
    frm_if.frm_valid = 1'b1;
    frm_if.frm_last  = last;
    tick_bpi();
    exp_mc = ~exp_mc;
    check("frame_mdf", mdf, exp_mdf);
    check("frame_mc", mc, exp_mc);
    check("frame_ready", frm_if.frm_ready, 1);
    step();
    check("ready_one_cycle", frm_if.frm_ready, 0);
    frm_if.frm_last = 1'b0;
  endtask

  task automatic run_gap();
    repeat (GAP_TICKS - 1) tick_bpi();
    check("gap_mdf_zero", mdf, 0);
    check("gap_no_done", done, 0);
    check("gap_busy", busy, 1);
    tick_bpi();
    check("gap_done", done, 1);
    check("gap_mc_hold", mc, exp_mc);
    step();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    rst = 1'b0; mm = 1'b0; go = 1'b0; bpiclk = 1'b0; fc_load = 1'b0;
    mop = MOP_NOP; fc_data = '0; exp_mc = 1'b0;
    frm_if.frm_data = '0; frm_if.frm_valid = 1'b0; frm_if.frm_last = 1'b0;
    step();
    step();
    check("rst_mdf", mdf, 0);
    check("rst_mc", mc, 0);
    check("rst_ready", frm_if.frm_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err_unr, 0);
    check("rst_busy", busy, 0);
    check("rst_fc_zero", fc_zero, 1);
    rst = 1'b1;
    step();

    // Basic stream of three frames, counter runs out on the third
    start(16'd3, MOP_WRP1);
    check("fc_zero_loaded", fc_zero, 0);
    send(9'h1A5, 1'b0, exp_of(9'h1A5));
    send(9'h05A, 1'b0, exp_of(9'h05A));
    send(9'h0FF, 1'b0, exp_of(9'h0FF));
    check("basic_fc_zero", fc_zero, 1);
    check("basic_mc_final", mc, 1);
    run_gap();
    check("basic_err", err_unr, 0);

    // Early last on frame 2 of 10
    start(16'd10, MOP_WRP2);
    send(9'h101, 1'b0, exp_of(9'h101));
    send(9'h0C3, 1'b1, exp_of(9'h0C3));
    check("early_fc", dut.fc, 8);
    check("early_fc_zero", fc_zero, 0);
    run_gap();

    // Underrun on the second tick
    start(16'd4, MOP_WRP3);
    send(9'h011, 1'b0, exp_of(9'h011));
    frm_if.frm_valid = 1'b0;
    tick_bpi();
    check("unr_done", done, 1);
    check("unr_err", err_unr, 1);
    check("unr_mc", mc, exp_mc);
    check("unr_mdf_hold", mdf, exp_of(9'h011));
    check("unr_no_ready", frm_if.frm_ready, 0);
    step();
    check("unr_idle", busy, 0);

    // Illegal starts
    mm = 1'b0; mop = MOP_WRP1; go = 1'b1;
    step();
    go = 1'b0;
    check("ill_mm0_busy", busy, 0);
    mm = 1'b1; mop = MOP_NOP; go = 1'b1;
    step();
    go = 1'b0;
    check("ill_nop_busy", busy, 0);
    check("ill_ready", frm_if.frm_ready, 0);
    check("ill_fc", dut.fc, 3);
    check("ill_err_kept", err_unr, 1);

    // go and fc_load while busy are ignored; then abort via mm
    start(16'd5, MOP_WRP2);
    send(9'h0AA, 1'b0, exp_of(9'h0AA));
    go = 1'b1;
    step();
    go = 1'b0;
    check("busy_go_ignored", busy, 1);
    fc_load = 1'b1; fc_data = 16'd9;
    step();
    fc_load = 1'b0;
    check("busy_load_ignored", dut.fc, 4);
    mm = 1'b0;
    step();
    check("abort_done", done, 1);
    check("abort_err", err_unr, 1);
    mm = 1'b1;
    step();
    check("abort_idle", busy, 0);

    // Abort coincident with a tick: no frame taken
    start(16'd5, MOP_WRP3);
    send(9'h033, 1'b0, exp_of(9'h033));
    frm_if.frm_data = 9'h044;
    frm_if.frm_valid = 1'b1;
    step();
    bpiclk = 1'b1;
    step();
    mm = 1'b0;
    step();
    check("race_done", done, 1);
    check("race_no_ready", frm_if.frm_ready, 0);
    check("race_mdf", mdf, exp_of(9'h033));
    check("race_mc", mc, exp_mc);
    check("race_err", err_unr, 1);
    bpiclk = 1'b0;
    mm = 1'b1;
    step();

    // Reset mid-transfer
    start(16'd5, MOP_WRP1);
    send(9'h055, 1'b0, exp_of(9'h055));
    rst = 1'b0;
    step();
    exp_mc = 1'b0;
    check("mrst_mdf", mdf, 0);
    check("mrst_mc", mc, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err_unr, 0);
    check("mrst_fc_zero", fc_zero, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_no_done", done, 0);
    end

    // Parity / passthrough of the MSB
    start(16'd3, MOP_WRP1);
    send(9'h003, 1'b0, 9'h003);
`ifdef MTMNT_PARITY_EN
    send(9'h007, 1'b0, 9'h107);
`else
    send(9'h007, 1'b0, 9'h007);
`endif
    send(9'h107, 1'b0, 9'h107);
    run_gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
